// File: rtl/pc_redirect_unit_pkg.sv
// Shared types and constants for the PC / fetch-redirect stage.
package pc_redirect_unit_pkg;

  typedef enum logic [1:0] {PR_IDLE, PR_RUN, PR_HOLD, PR_FLUSH} pr_state_t;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/pc_redirect_unit_if.sv
// Fetch request handshake between the PC stage (master) and instruction memory (slave).
interface pc_redirect_unit_if #(
  parameter int unsigned AW = 32
);
  logic          fetch_valid;
  logic          fetch_ready;
  logic [AW-1:0] pc;

  modport master (output fetch_valid, output pc, input fetch_ready);
  modport slave  (input fetch_valid, input pc, output fetch_ready);
endinterface

// File: rtl/pc_redirect_unit_flush_counter.sv
// Down-counter of remaining wrong-path slots after a redirect; load wins over decrement.
module pc_redirect_unit_flush_counter #(
  parameter int unsigned FlushCycles = 2,
  localparam int unsigned CntW = $clog2(FlushCycles + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);
  localparam logic [CntW-1:0] LoadVal = CntW'(FlushCycles - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LoadVal;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/pc_redirect_unit.sv
// PC holder and fetch-redirect FSM; squashes wrong-path slots after taken jumps.
// Optional PC_REDIRECT_STATS_EN adds saturating taken_count / flush_count outputs.
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter int unsigned   AW           = 32,
  parameter logic [AW-1:0] RESET_PC     = '0,
  parameter int unsigned   FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  pc_redirect_unit_if.master fetch_if,
  input  logic               stall,
  input  logic               jump_uncond,
  input  logic               jump_cond_true,
  input  logic [AW-1:0]      jump_target,
  output logic               flush_if_id,
  output logic               flush_id_ex,
  output logic               redirect_busy
`ifdef PC_REDIRECT_STATS_EN
  ,
  output logic [31:0]        taken_count,
  output logic [31:0]        flush_count
`endif
);
  localparam logic [AW-1:0] PcStep    = AW'(INSTR_BYTES);
  localparam logic [AW-1:0] AlignMask = ~AW'(INSTR_BYTES - 1);

  pr_state_t     state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          valid_q, valid_d;
  logic          req_valid, req_done;
  logic          accept;
  logic          cnt_load, cnt_dec, cnt_zero;

  // Jumps are ignored in IDLE: nothing has been fetched yet, so there is no wrong path.
  assign accept   = (jump_uncond | jump_cond_true) & (state_q != PR_IDLE);
  assign req_done = req_valid & fetch_if.fetch_ready;

  pc_redirect_unit_flush_counter #(
    .FlushCycles (FLUSH_CYCLES)
  ) u_flush_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .zero_o (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PR_IDLE;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (state_q == PR_IDLE) begin
      valid_d = 1'b1;
      state_d = PR_RUN;
    end else if (accept) begin
      pc_d     = jump_target & AlignMask;
      valid_d  = 1'b1;
      cnt_load = 1'b1;
      state_d  = fetch_if.fetch_ready ? PR_FLUSH : PR_HOLD;
    end else begin
      if (req_done) begin
        pc_d = pc_q + PcStep;
      end
      case (state_q)
        PR_HOLD: begin
          if (req_done) state_d = PR_FLUSH;
        end
        PR_FLUSH: begin
          cnt_dec = req_done;
          if (cnt_zero) state_d = PR_RUN;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_valid     = valid_q;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    redirect_busy = (state_q == PR_HOLD) || (state_q == PR_FLUSH);
    // A decode stall withdraws the sequential request; the PC is simply held.
    if ((state_q == PR_RUN) && stall) begin
      req_valid = 1'b0;
    end
    if (accept) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if ((state_q == PR_FLUSH) && !cnt_zero) begin
      flush_if_id = 1'b1;
    end
  end

  assign fetch_if.fetch_valid = req_valid;
  assign fetch_if.pc          = pc_q;

`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] taken_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (accept && (taken_cnt_q != '1)) taken_cnt_q <= taken_cnt_q + 32'd1;
      if (flush_if_id && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign taken_count = taken_cnt_q;
  assign flush_count = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: per-cycle expectations pushed to a scoreboard and checked.
module tb_pc_redirect_unit;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        v;
    logic        fi;
    logic        fe;
    logic        busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        jump_uncond;
  logic        jump_cond_true;
  logic [31:0] jump_target;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        redirect_busy;
`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] taken_count;
  logic [31:0] flush_count;
`endif

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  pc_redirect_unit_if #(.AW(32)) fetch_if ();

  pc_redirect_unit #(
    .AW           (32),
    .RESET_PC     (32'h100),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_if       (fetch_if),
    .stall          (stall),
    .jump_uncond    (jump_uncond),
    .jump_cond_true (jump_cond_true),
    .jump_target    (jump_target),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .redirect_busy  (redirect_busy)
`ifdef PC_REDIRECT_STATS_EN
    ,
    .taken_count    (taken_count),
    .flush_count    (flush_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_now(input string tag, input logic [31:0] epc,
                            input logic ev, input logic efi, input logic efe, input logic ebusy);
    exp_t e;
    sb.push_back('{tag, epc, ev, efi, efe, ebusy});
    e = sb.pop_front();
    check({e.tag, ".pc"},    fetch_if.pc,                e.pc);
    check({e.tag, ".valid"}, 32'(fetch_if.fetch_valid),  32'(e.v));
    check({e.tag, ".fifid"}, 32'(flush_if_id),           32'(e.fi));
    check({e.tag, ".fidex"}, 32'(flush_id_ex),           32'(e.fe));
    check({e.tag, ".busy"},  32'(redirect_busy),         32'(e.busy));
  endtask

  // Drive one cycle's inputs at the falling edge, then check outputs 1ns later.
  task automatic step(input string tag, input logic st, input logic ju, input logic jc,
                      input logic [31:0] tgt, input logic rdy, input logic [31:0] epc,
                      input logic ev, input logic efi, input logic efe, input logic ebusy);
    @(negedge clk);
    stall                = st;
    jump_uncond          = ju;
    jump_cond_true       = jc;
    jump_target          = tgt;
    fetch_if.fetch_ready = rdy;
    #1;
    expect_now(tag, epc, ev, efi, efe, ebusy);
  endtask

  initial begin
    rst_n                = 1'b1;
    stall                = 1'b0;
    jump_uncond          = 1'b0;
    jump_cond_true       = 1'b0;
    jump_target          = '0;
    fetch_if.fetch_ready = 1'b1;
    #1 rst_n = 1'b0;

    step("reset", 0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step("idle",  0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0);
    step("seq0",  0, 0, 0, 0, 1, 32'h100, 1, 0, 0, 0);
    step("seq1",  0, 0, 0, 0, 1, 32'h104, 1, 0, 0, 0);
    step("seq2",  0, 0, 0, 0, 1, 32'h108, 1, 0, 0, 0);

    // Conditional taken with a misaligned target.
    step("cjmp",  0, 0, 1, 32'h203, 1, 32'h10C, 1, 1, 1, 0);
    step("fl0",   0, 0, 0, 0, 1, 32'h200, 1, 1, 0, 1);
    step("fl1",   0, 0, 0, 0, 1, 32'h204, 1, 0, 0, 1);

    // Stall for three cycles, then resume.
    step("stl0",  1, 0, 0, 0, 1, 32'h208, 0, 0, 0, 0);
    step("stl1",  1, 0, 0, 0, 1, 32'h208, 0, 0, 0, 0);
    step("stl2",  1, 0, 0, 0, 1, 32'h208, 0, 0, 0, 0);
    step("rel",   0, 0, 0, 0, 1, 32'h208, 1, 0, 0, 0);

    // Taken while imem is not ready -> HOLD at target.
    step("hjmp",  0, 1, 0, 32'h300, 0, 32'h20C, 1, 1, 1, 0);
    step("hold0", 0, 0, 0, 0, 0, 32'h300, 1, 0, 0, 1);
    step("hold1", 0, 0, 0, 0, 0, 32'h300, 1, 0, 0, 1);
    step("hacc",  0, 0, 0, 0, 1, 32'h300, 1, 0, 0, 1);

    // Second taken during FLUSH: youngest wins, counter reloads.
    step("rjmp",  0, 0, 1, 32'h400, 1, 32'h304, 1, 1, 1, 1);
    step("rfl0",  0, 0, 0, 0, 1, 32'h400, 1, 1, 0, 1);
    step("rfl1",  0, 0, 0, 0, 1, 32'h404, 1, 0, 0, 1);
    step("rrun",  0, 0, 0, 0, 1, 32'h408, 1, 0, 0, 0);

    // Wrap-around through the top of the address space.
    step("wjmp",  0, 1, 0, 32'hFFFF_FFFF, 1, 32'h40C, 1, 1, 1, 0);
    step("wtop",  0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 1, 0, 1);
    step("wrap",  0, 0, 0, 0, 1, 32'h0, 1, 0, 0, 1);
    step("wrun",  0, 0, 0, 0, 1, 32'h4, 1, 0, 0, 0);

    // Async reset in the middle of FLUSH.
    step("xjmp",  0, 0, 1, 32'h500, 1, 32'h8, 1, 1, 1, 0);
    step("xfl",   0, 0, 0, 0, 1, 32'h500, 1, 1, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    expect_now("arst", 32'h100, 0, 0, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Release with imem not ready: PC holds at RESET_PC.
    step("ridle", 0, 0, 0, 0, 0, 32'h100, 0, 0, 0, 0);
    step("nrdy0", 0, 0, 0, 0, 0, 32'h100, 1, 0, 0, 0);
    step("nrdy1", 0, 0, 0, 0, 0, 32'h100, 1, 0, 0, 0);
    step("rdy",   0, 0, 0, 0, 1, 32'h100, 1, 0, 0, 0);

    // Taken during stall still redirects.
    step("sjmp",  1, 1, 0, 32'h600, 1, 32'h104, 0, 1, 1, 0);
    step("sfl0",  0, 0, 0, 0, 1, 32'h600, 1, 1, 0, 1);
    step("sfl1",  0, 0, 0, 0, 1, 32'h604, 1, 0, 0, 1);
    step("srun",  0, 0, 0, 0, 1, 32'h608, 1, 0, 0, 0);

`ifdef PC_REDIRECT_STATS_EN
    check("taken_count", taken_count, 32'd1);
    check("flush_count", flush_count, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
